// File: rtl/piezo_pkg.sv
// Shared types, default cadence/tone constants and scaling helper for the piezo alarm sequencer.
// PIEZO_FAST_SIM_EN shrinks the cadence (>>10) and tone (>>4) constants for short full-chip sims.
package piezo_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } piezo_state_e;

   localparam logic [47:0] TONE_HALF_DEF = {16'd12500, 16'd16667, 16'd25000};
   localparam logic [77:0] ON_LEN_DEF    = {26'd50_000_000, 26'd12_500_000, 26'd5_000_000};
   localparam logic [77:0] PERIOD_DEF    = {26'd50_000_000, 26'd25_000_000, 26'd50_000_000};

`ifdef PIEZO_FAST_SIM_EN
   localparam int unsigned CAD_SHIFT  = 32'd10;
   localparam int unsigned TONE_SHIFT = 32'd4;
`else
   localparam int unsigned CAD_SHIFT  = 32'd0;
   localparam int unsigned TONE_SHIFT = 32'd0;
`endif

   // A zero-length tone or cadence would lock the counters, so the scaled value never drops below 1.
   function automatic logic [31:0] scale_floor(input logic [31:0] val, input int unsigned sh);
      logic [31:0] s;
      s = val >> sh;
      if (s == 32'd0) begin
         return 32'd1;
      end else begin
         return s;
      end
   endfunction

endpackage

// File: rtl/piezo_alarm_seq_if.sv
// Request/status bundle between the segway status logic and the piezo alarm sequencer.
interface piezo_alarm_seq_if #(
   parameter int NUM_CH = 3
);
   localparam int AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] req;
   logic              mute;
   logic              piezo;
   logic              piezo_n;
   logic [AW-1:0]     active_ch;
   logic              busy;

   modport master (
      output req, mute,
      input  piezo, piezo_n, active_ch, busy
   );

   modport slave (
      input  req, mute,
      output piezo, piezo_n, active_ch, busy
   );

endinterface

// File: rtl/piezo_tone_gen.sv
// Tone half-period counter with phase toggle; drives the gated, registered piezo pair.
module piezo_tone_gen #(
   parameter int TONE_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              run,
   input  logic              gate,
   input  logic [TONE_W-1:0] half,
   output logic              tone,
   output logic              tone_n
);

   logic [TONE_W-1:0] cnt_q, cnt_d;
   logic              phase_q, phase_d;
   logic              tone_q, tone_d;
   logic              tone_n_q, tone_n_d;

   // Phase restarts high on clear so every burst begins with piezo=1.
   always_comb begin
      cnt_d    = cnt_q;
      phase_d  = phase_q;
      if (clr) begin
         cnt_d   = {TONE_W{1'b0}};
         phase_d = 1'b1;
      end else if (run) begin
         if (cnt_q == (half - TONE_W'(1))) begin
            cnt_d   = {TONE_W{1'b0}};
            phase_d = ~phase_q;
         end else begin
            cnt_d   = cnt_q + TONE_W'(1);
            phase_d = phase_q;
         end
      end else begin
         cnt_d   = cnt_q;
         phase_d = phase_q;
      end
      tone_d   = gate & phase_d;
      tone_n_d = gate & ~phase_d;
   end

   // Counter, phase and output drive registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= {TONE_W{1'b0}};
         phase_q  <= 1'b0;
         tone_q   <= 1'b0;
         tone_n_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         tone_q   <= tone_d;
         tone_n_q <= tone_n_d;
      end
   end

   assign tone   = tone_q;
   assign tone_n = tone_n_q;

endmodule

// File: rtl/piezo_alarm_seq.sv
// Multi-channel piezo alarm sequencer: priority select, on/off cadence and differential tone drive.
// PIEZO_FAST_SIM_EN (see piezo_pkg) scales the per-channel constants only.
module piezo_alarm_seq
   import piezo_pkg::*;
#(
   parameter int                        NUM_CH    = 3,
   parameter int                        CNT_W     = 26,
   parameter int                        TONE_W    = 16,
   parameter logic [NUM_CH*TONE_W-1:0]  TONE_HALF = TONE_HALF_DEF,
   parameter logic [NUM_CH*CNT_W-1:0]   ON_LEN    = ON_LEN_DEF,
   parameter logic [NUM_CH*CNT_W-1:0]   PERIOD    = PERIOD_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   piezo_alarm_seq_if.slave   bus
);

   localparam int AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] req_s;
   logic              mute_s;
   logic [AW-1:0]     winner_s;
   logic              any_s;

   piezo_state_e      state_q, state_d;
   logic [AW-1:0]     active_q, active_d;
   logic [CNT_W-1:0]  cad_q, cad_d;
   logic              busy_q, busy_d;
   logic              restart_s;

   logic [TONE_W-1:0] half_arr_s   [NUM_CH];
   logic [CNT_W-1:0]  on_len_arr_s [NUM_CH];
   logic [CNT_W-1:0]  period_arr_s [NUM_CH];
   logic [TONE_W-1:0] half_s;
   logic [CNT_W-1:0]  on_len_s;
   logic [CNT_W-1:0]  period_s;

   logic              tone_clr_s;
   logic              tone_run_s;
   logic              tone_gate_s;
   logic              piezo_s;
   logic              piezo_n_s;

   assign req_s  = bus.req;
   assign mute_s = bus.mute;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_eff
      assign half_arr_s[c]   = TONE_W'(scale_floor(32'(TONE_HALF[c*TONE_W +: TONE_W]), TONE_SHIFT));
      assign on_len_arr_s[c] = CNT_W'(scale_floor(32'(ON_LEN[c*CNT_W +: CNT_W]), CAD_SHIFT));
      assign period_arr_s[c] = CNT_W'(scale_floor(32'(PERIOD[c*CNT_W +: CNT_W]), CAD_SHIFT));
   end

   assign half_s   = half_arr_s[active_q];
   assign on_len_s = on_len_arr_s[active_q];
   assign period_s = period_arr_s[active_q];

   // Highest set request bit wins.
   always_comb begin
      winner_s = {AW{1'b0}};
      any_s    = |req_s;
      for (int i = 0; i < NUM_CH; i++) begin
         if (req_s[i]) begin
            winner_s = AW'(i);
         end else begin
            winner_s = winner_s;
         end
      end
   end

   // Sequencing FSM; a changed winner covers both pre-emption and hand-back after a drop.
   always_comb begin
      state_d   = state_q;
      active_d  = active_q;
      cad_d     = cad_q;
      restart_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_s) begin
               state_d   = ON;
               active_d  = winner_s;
               cad_d     = {CNT_W{1'b0}};
               restart_s = 1'b1;
            end else begin
               active_d = {AW{1'b0}};
               cad_d    = {CNT_W{1'b0}};
            end
         end
         ON, OFF: begin
            if (!any_s) begin
               state_d  = IDLE;
               active_d = {AW{1'b0}};
               cad_d    = {CNT_W{1'b0}};
            end else if (winner_s != active_q) begin
               state_d   = ON;
               active_d  = winner_s;
               cad_d     = {CNT_W{1'b0}};
               restart_s = 1'b1;
            end else if (state_q == ON) begin
               if ((cad_q == (on_len_s - CNT_W'(1))) && (on_len_s < period_s)) begin
                  state_d = OFF;
                  cad_d   = cad_q + CNT_W'(1);
               end else if (cad_q == (period_s - CNT_W'(1))) begin
                  cad_d = {CNT_W{1'b0}};
               end else begin
                  cad_d = cad_q + CNT_W'(1);
               end
            end else begin
               if (cad_q == (period_s - CNT_W'(1))) begin
                  state_d   = ON;
                  cad_d     = {CNT_W{1'b0}};
                  restart_s = 1'b1;
               end else begin
                  cad_d = cad_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d  = IDLE;
            active_d = {AW{1'b0}};
            cad_d    = {CNT_W{1'b0}};
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // Tone runs through mute so unmuting lands in the unmuted phase.
   always_comb begin
      tone_clr_s  = restart_s | (state_d != ON);
      tone_run_s  = (state_d == ON);
      tone_gate_s = (state_d == ON) & ~mute_s;
   end

   // FSM state, channel, cadence and busy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         active_q <= {AW{1'b0}};
         cad_q    <= {CNT_W{1'b0}};
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         cad_q    <= cad_d;
         busy_q   <= busy_d;
      end
   end

   piezo_tone_gen #(
      .TONE_W (TONE_W)
   ) u_tone (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (tone_clr_s),
      .run    (tone_run_s),
      .gate   (tone_gate_s),
      .half   (half_s),
      .tone   (piezo_s),
      .tone_n (piezo_n_s)
   );

   assign bus.piezo     = piezo_s;
   assign bus.piezo_n   = piezo_n_s;
   assign bus.active_ch = active_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_piezo_alarm_seq.sv
// Self-checking bench for piezo_alarm_seq: directed scenarios plus random requests vs. a timing model.
module tb_piezo_alarm_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   piezo_alarm_seq_if #(.NUM_CH(3)) bus ();

   piezo_alarm_seq #(
      .NUM_CH    (3),
      .CNT_W     (26),
      .TONE_W    (16),
      .TONE_HALF ({16'd2, 16'd3, 16'd4}),
      .ON_LEN    ({26'd8, 26'd6, 26'd4}),
      .PERIOD    ({26'd8, 26'd12, 26'd10})
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;

   // Per-channel constants, index = channel number.
   int HALF [3] = '{4, 3, 2};
   int ONL  [3] = '{4, 6, 8};
   int PER  [3] = '{10, 12, 8};

   // Model: channel being sounded and cycles elapsed since its sequence started.
   bit m_busy = 1'b0;
   int m_ch   = 0;
   int m_k    = 0;
   bit m_mute = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input logic [2:0] r, input logic m);
      int win;
      win = -1;
      for (int i = 0; i < 3; i++) begin
         if (r[i]) win = i;
      end
      m_mute = m;
      if (win < 0) begin
         m_busy = 1'b0;
         m_ch   = 0;
         m_k    = 0;
      end else if (!m_busy || win != m_ch) begin
         m_busy = 1'b1;
         m_ch   = win;
         m_k    = 0;
      end else begin
         m_k++;
      end
   endtask

   task automatic check_all(input string tag);
      bit e_p, e_pn, on, ph;
      int p, t;
      e_p = 1'b0;
      e_pn = 1'b0;
      if (m_busy) begin
         p  = m_k % PER[m_ch];
         on = (p < ONL[m_ch]);
         t  = (ONL[m_ch] == PER[m_ch]) ? m_k : p;
         ph = ((t / HALF[m_ch]) % 2) == 0;
         e_p  = on && !m_mute && ph;
         e_pn = on && !m_mute && !ph;
      end
      check({tag, "_piezo"},   32'(bus.piezo),     32'(e_p));
      check({tag, "_piezo_n"}, 32'(bus.piezo_n),   32'(e_pn));
      check({tag, "_busy"},    32'(bus.busy),      32'(m_busy));
      check({tag, "_act"},     32'(bus.active_ch), m_busy ? 32'(m_ch) : 32'd0);
      check({tag, "_excl"},    32'(bus.piezo & bus.piezo_n), 32'd0);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_step(bus.req, bus.mute);
      #1;
      check_all(tag);
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   initial begin
      bus.req  = 3'b000;
      bus.mute = 1'b0;
      #2;
      check_all("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      run(3, "idle");

      // Channel 0: 4 clocks of tone, 6 clocks silent.
      bus.req = 3'b001;
      step("ch0");
      check("ch0_latency", 32'(bus.piezo), 32'd1);
      run(24, "ch0");

      bus.req = 3'b000;
      run(3, "drop");

      // Channel 2: continuous tone.
      bus.req = 3'b100;
      run(20, "ch2_cont");
      bus.req = 3'b000;
      run(2, "idle2");

      // Pre-empt ch0 mid-OFF, then hand back.
      bus.req = 3'b001;
      run(7, "pre_ch0");
      bus.req = 3'b101;
      step("preempt");
      check("preempt_ch", 32'(bus.active_ch), 32'd2);
      run(10, "preempt_run");
      bus.req = 3'b001;
      step("handback");
      check("handback_ch", 32'(bus.active_ch), 32'd0);
      run(15, "handback_run");

      // Mute pulse during ch1 ON.
      bus.req = 3'b010;
      run(3, "ch1");
      bus.mute = 1'b1;
      run(5, "mute");
      bus.mute = 1'b0;
      run(15, "unmute");

      // Asynchronous reset mid-ON.
      bus.req = 3'b000;
      run(1, "pre_rst");
      bus.req = 3'b010;
      run(3, "ch1_on");
      rst_n = 1'b0;
      #1;
      m_busy = 1'b0;
      m_ch   = 0;
      m_k    = 0;
      check("rst_async_piezo", 32'(bus.piezo), 32'd0);
      check("rst_async_busy",  32'(bus.busy),  32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step("post_rst");
      check("rst_restart", 32'(bus.piezo), 32'd1);
      run(5, "post_rst_run");

      // Random requests and mute.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) bus.req = 3'($urandom_range(0, 7));
         bus.mute = ($urandom_range(0, 9) == 0);
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
